alu_arb: RTL and testbench

- Arbiter/scheduler that shares one combinational 32-bit RISC-V integer ALU between two requesters: port 0 is the integer pipeline and port 1 is the address/branch helper.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block performs round-robin arbitration, drives the ALU operands and operation select, and registers the result.
- There is one result register per requester, so one requester stalling its response does not block the other.

---
 rtl/alu_arb_if.sv | 26 ++
 rtl/alu_arb.sv | 130 +++++++++++++
 tb/tb_alu_arb.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/alu_arb_if.sv
// Requester-side bundle for alu_arb: one valid/ready request channel plus
// one valid/ready response channel. The arbiter uses the slave modport and
// the requester (pipeline or helper) uses the master modport.
interface alu_arb_if #(
  parameter int W   = 32,
  parameter int OPW = 3
);
  logic           req_valid;
  logic           req_ready;
  logic [OPW-1:0] req_op;
  logic [W-1:0]   req_a;
  logic [W-1:0]   req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_data;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/alu_arb.sv
// alu_arb: round-robin sharing of one combinational ALU between two
// requesters, with a registered result slot per requester so a stalled
// response on one side never blocks the other.
// Optional macro ALU_ARB_PERF_EN adds grant and conflict counters.
//
// state   | meaning
// PREF_0  | requester 0 wins when both are eligible
// PREF_1  | requester 1 wins when both are eligible
module alu_arb #(
  parameter int W   = 32,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst,
  alu_arb_if.slave       port0,
  alu_arb_if.slave       port1,
  output logic [W-1:0]   alu_op_a,
  output logic [W-1:0]   alu_op_b,
  output logic [OPW-1:0] alu_sel,
  input  logic [W-1:0]   alu_result
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0]    perf_grant0,
  output logic [31:0]    perf_grant1,
  output logic [31:0]    perf_conflict
`endif
);

  typedef enum logic {PREF_0 = 1'b0, PREF_1 = 1'b1} rr_t;

  localparam logic [OPW-1:0] OP_RSVD = {OPW{1'b1}};

  rr_t            rr_q, rr_d;
  logic           elig0, elig1;
  logic           grant0, grant1;
  logic [OPW-1:0] gnt_op;
  logic [W-1:0]   result;
  logic [W-1:0]   a_q, b_q;
  logic [OPW-1:0] sel_q;
  logic           rsp0_valid_q, rsp1_valid_q;
  logic [W-1:0]   rsp0_data_q, rsp1_data_q;

  // Pointer register; only moves after a grant.
  always_ff @(posedge clk) begin
    if (rst) rr_q <= PREF_0;
    else     rr_q <= rr_d;
  end

  // Arbitration, ALU operand drive and result gating.
  always_comb begin
    rr_d     = rr_q;
    elig0    = port0.req_valid && (!rsp0_valid_q || port0.rsp_ready);
    elig1    = port1.req_valid && (!rsp1_valid_q || port1.rsp_ready);
    grant0   = elig0 && (!elig1 || rr_q == PREF_0);
    grant1   = elig1 && (!elig0 || rr_q == PREF_1);
    gnt_op   = grant1 ? port1.req_op : port0.req_op;
    alu_op_a = a_q;
    alu_op_b = b_q;
    alu_sel  = sel_q;
    if (grant0 || grant1) begin
      alu_op_a = grant1 ? port1.req_a : port0.req_a;
      alu_op_b = grant1 ? port1.req_b : port0.req_b;
      // Reserved op runs as ADD on the ALU; its result is zeroed below.
      alu_sel  = (gnt_op == OP_RSVD) ? '0 : gnt_op;
    end
    result = (gnt_op == OP_RSVD) ? '0 : alu_result;
    if (grant0)      rr_d = PREF_1;
    else if (grant1) rr_d = PREF_0;
  end

  // Hold last ALU drive so idle cycles do not toggle the operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sel_q <= '0;
    end else begin
      a_q   <= alu_op_a;
      b_q   <= alu_op_b;
      sel_q <= alu_sel;
    end
  end

  // Per-requester result slots: load on grant, clear valid on consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      if (grant0) begin
        rsp0_valid_q <= 1'b1;
        rsp0_data_q  <= result;
      end else if (port0.rsp_ready) begin
        rsp0_valid_q <= 1'b0;
      end
      if (grant1) begin
        rsp1_valid_q <= 1'b1;
        rsp1_data_q  <= result;
      end else if (port1.rsp_ready) begin
        rsp1_valid_q <= 1'b0;
      end
    end
  end

  assign port0.req_ready = grant0;
  assign port1.req_ready = grant1;
  assign port0.rsp_valid = rsp0_valid_q;
  assign port1.rsp_valid = rsp1_valid_q;
  assign port0.rsp_data  = rsp0_data_q;
  assign port1.rsp_data  = rsp1_data_q;

`ifdef ALU_ARB_PERF_EN
  // Grant counters and lost-arbitration counter, all wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant0   <= '0;
      perf_grant1   <= '0;
      perf_conflict <= '0;
    end else begin
      if (grant0) perf_grant0 <= perf_grant0 + 32'd1;
      if (grant1) perf_grant1 <= perf_grant1 + 32'd1;
      if (port0.req_valid && port1.req_valid && (grant0 ^ grant1))
        perf_conflict <= perf_conflict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arb.sv
// Directed bench for alu_arb with a behavioural ALU attached.
module tb_alu_arb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] alu_op_a, alu_op_b, alu_result;
  logic [2:0]  alu_sel;
  int          errors = 0;
  int          checks = 0;
`ifdef ALU_ARB_PERF_EN
  logic [31:0] perf_grant0, perf_grant1, perf_conflict;
`endif

  alu_arb_if #(.W(32), .OPW(3)) p0 ();
  alu_arb_if #(.W(32), .OPW(3)) p1 ();

  alu_arb #(.W(32), .OPW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .port0      (p0),
    .port1      (p1),
    .alu_op_a   (alu_op_a),
    .alu_op_b   (alu_op_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_grant0   (perf_grant0),
    .perf_grant1   (perf_grant1),
    .perf_conflict (perf_conflict)
`endif
  );

  always #5 clk = ~clk;

  // Reference ALU
  always_comb begin
    case (alu_sel)
      3'd0:    alu_result = alu_op_a + alu_op_b;
      3'd1:    alu_result = (alu_op_a < alu_op_b) ? 32'd1 : 32'd0;
      3'd2:    alu_result = alu_op_a | alu_op_b;
      3'd3:    alu_result = alu_op_a & alu_op_b;
      3'd4:    alu_result = alu_op_a ^ alu_op_b;
      3'd5:    alu_result = alu_op_a >> alu_op_b[4:0];
      3'd6:    alu_result = alu_op_a << alu_op_b[4:0];
      default: alu_result = 32'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    p0.req_valid = 0; p0.req_op = 0; p0.req_a = 0; p0.req_b = 0; p0.rsp_ready = 0;
    p1.req_valid = 0; p1.req_op = 0; p1.req_a = 0; p1.req_b = 0; p1.rsp_ready = 0;
    step(); step();
    rst = 0;
    #1;
    chk("rst_rsp0_valid", 32'(p0.rsp_valid), 32'd0);
    chk("rst_rsp1_valid", 32'(p1.rsp_valid), 32'd0);
    chk("rst_rsp0_data", p0.rsp_data, 32'd0);
    chk("rst_rsp1_data", p1.rsp_data, 32'd0);
    chk("idle_req0_ready", 32'(p0.req_ready), 32'd0);

    // Single ADD
    p0.req_valid = 1; p0.req_op = 3'd0; p0.req_a = 5; p0.req_b = 7; p0.rsp_ready = 1;
    #1;
    chk("single_req0_ready", 32'(p0.req_ready), 32'd1);
    chk("single_alu_a", alu_op_a, 32'd5);
    step();
    p0.req_valid = 0;
    chk("single_rsp_valid", 32'(p0.rsp_valid), 32'd1);
    chk("single_rsp_data", p0.rsp_data, 32'd12);
    step();
    chk("single_rsp_drop", 32'(p0.rsp_valid), 32'd0);

    // Contention from reset
    rst = 1; step(); rst = 0;
    p0.req_valid = 1; p0.req_op = 3'd4; p0.req_a = 32'hF0F0; p0.req_b = 32'h0FF0; p0.rsp_ready = 1;
    p1.req_valid = 1; p1.req_op = 3'd6; p1.req_a = 1; p1.req_b = 4; p1.rsp_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("cont_ready0_%0d", k), 32'(p0.req_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("cont_ready1_%0d", k), 32'(p1.req_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
      step();
      if (k % 2 == 0) begin
        chk($sformatf("cont_rsp0_%0d", k), p0.rsp_data, 32'h0000FF00);
        chk($sformatf("cont_v0_%0d", k), 32'(p0.rsp_valid), 32'd1);
        chk($sformatf("cont_v1_%0d", k), 32'(p1.rsp_valid), 32'd0);
      end else begin
        chk($sformatf("cont_rsp1_%0d", k), p1.rsp_data, 32'd16);
        chk($sformatf("cont_v1_%0d", k), 32'(p1.rsp_valid), 32'd1);
        chk($sformatf("cont_v0_%0d", k), 32'(p0.rsp_valid), 32'd0);
      end
    end
`ifdef ALU_ARB_PERF_EN
    chk("perf_conflict", perf_conflict, 32'd4);
    chk("perf_grant_sum", perf_grant0 + perf_grant1, 32'd4);
    chk("perf_grant0", perf_grant0, 32'd2);
`endif

    // Backpressure isolation: rsp1 holds 16, req0 streams
    p1.rsp_ready = 0;
    p1.req_op = 3'd0; p1.req_a = 100; p1.req_b = 1;
    p0.req_op = 3'd0; p0.req_b = 10;
    for (int i = 0; i < 4; i++) begin
      p0.req_a = 32'(i);
      #1;
      chk($sformatf("bp_ready0_%0d", i), 32'(p0.req_ready), 32'd1);
      chk($sformatf("bp_ready1_%0d", i), 32'(p1.req_ready), 32'd0);
      step();
      chk($sformatf("bp_rsp0_%0d", i), p0.rsp_data, 32'(i + 10));
      chk($sformatf("bp_rsp1_hold_%0d", i), p1.rsp_data, 32'd16);
      chk($sformatf("bp_v1_hold_%0d", i), 32'(p1.rsp_valid), 32'd1);
    end
    p0.req_valid = 0;
    p1.rsp_ready = 1;
    #1;
    chk("bp_release_ready1", 32'(p1.req_ready), 32'd1);
    step();
    p1.req_valid = 0;
    chk("bp_release_data", p1.rsp_data, 32'd101);
    chk("bp_release_valid", 32'(p1.rsp_valid), 32'd1);
    step();

    // Back-to-back reload on port 0
    p0.req_valid = 1; p0.req_op = 3'd5; p0.req_a = 32'h80000000; p0.req_b = 31; p0.rsp_ready = 1;
    step();
    chk("b2b_srl_valid", 32'(p0.rsp_valid), 32'd1);
    chk("b2b_srl_data", p0.rsp_data, 32'd1);
    p0.req_op = 3'd1; p0.req_a = 3; p0.req_b = 5;
    step();
    p0.req_valid = 0;
    chk("b2b_slt_valid", 32'(p0.rsp_valid), 32'd1);
    chk("b2b_slt_data", p0.rsp_data, 32'd1);
    step();
    chk("b2b_drop", 32'(p0.rsp_valid), 32'd0);

    // Reset mid-operation
    p0.req_valid = 1; p0.req_op = 3'd0; p0.req_a = 1; p0.req_b = 2; p0.rsp_ready = 0;
    step();
    chk("mid_pre_valid", 32'(p0.rsp_valid), 32'd1);
    rst = 1; p1.req_valid = 1; p1.req_op = 3'd2; p1.req_a = 8; p1.req_b = 1;
    step();
    rst = 0;
    chk("mid_rsp0_valid", 32'(p0.rsp_valid), 32'd0);
    chk("mid_rsp0_data", p0.rsp_data, 32'd0);
    chk("mid_rsp1_valid", 32'(p1.rsp_valid), 32'd0);
    p0.rsp_ready = 1; p1.rsp_ready = 1;
    #1;
    chk("mid_pref_ready0", 32'(p0.req_ready), 32'd1);
    chk("mid_pref_ready1", 32'(p1.req_ready), 32'd0);
    step();
    p0.req_valid = 0; p1.req_valid = 0;
    chk("mid_after_data", p0.rsp_data, 32'd3);
    step();
    chk("mid_drain1_valid", 32'(p1.rsp_valid), 32'd0);

    // Reserved op on port 1
    p1.req_valid = 1; p1.req_op = 3'd7; p1.req_a = 3; p1.req_b = 4;
    #1;
    chk("op7_alu_sel", 32'(alu_sel), 32'd0);
    step();
    p1.req_valid = 0;
    chk("op7_rsp_data", p1.rsp_data, 32'd0);
    chk("op7_rsp_valid", 32'(p1.rsp_valid), 32'd1);
    #1;
    chk("idle_hold_alu_a", alu_op_a, 32'd3);
    chk("idle_hold_alu_b", alu_op_b, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
